// File: rtl/duty_cycle_40.sv
// rtl/duty_cycle_40.sv - registered fixed-duty waveform / strobe generator with exposed phase counter; DUTY40_TICK_EN adds period_tick
module duty_cycle_40 #(
   parameter int PERIOD      = 5,
   parameter int HIGH_CYCLES = 2,
   parameter int CW          = (PERIOD <= 2) ? 1 : $clog2(PERIOD)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          en,
   output logic          clk_out,
   output logic [CW-1:0] count
`ifdef DUTY40_TICK_EN
   ,
   output logic          period_tick
`endif
);

   // Both constants fit in CW bits because HIGH_CYCLES < PERIOD.
   localparam logic [CW-1:0] LAST = CW'(PERIOD - 1);
   localparam logic [CW-1:0] HIGH = CW'(HIGH_CYCLES);

   generate
      if (PERIOD < 2 || HIGH_CYCLES < 1 || HIGH_CYCLES >= PERIOD) begin : g_bad_params
         $error("duty_cycle_40: need PERIOD >= 2 and 1 <= HIGH_CYCLES < PERIOD");
      end
   endgenerate

   logic [CW-1:0] count_q;
   logic [CW-1:0] count_d;
   logic          clk_out_q;

   // Next phase: wrap exactly at PERIOD-1 so count never leaves 0..PERIOD-1.
   always_comb begin
      count_d = (count_q == LAST) ? '0 : count_q + CW'(1);
   end

   // Phase and waveform registers; reset parks at PERIOD-1 so the first
   // enabled edge lands on phase 0 and starts a full high phase.
   always_ff @(posedge clk) begin
      if (rst) begin
         count_q   <= LAST;
         clk_out_q <= 1'b0;
      end else if (en) begin
         count_q   <= count_d;
         clk_out_q <= (count_d < HIGH);
      end
   end

`ifdef DUTY40_TICK_EN
   logic tick_q;

   // Start-of-period pulse, coincident with the rising edge of clk_out.
   always_ff @(posedge clk) begin
      if (rst) begin
         tick_q <= 1'b0;
      end else begin
         tick_q <= en & (count_d == '0);
      end
   end

   assign period_tick = tick_q;
`endif

   assign clk_out = clk_out_q;
   assign count   = count_q;

endmodule

// File: tb/tb_duty_cycle_40.sv
// tb/tb_duty_cycle_40.sv - randomized self-checking bench for duty_cycle_40 at three parameter points
module tb_duty_cycle_40;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic en  = 1'b0;

   logic       out5,  out10,  out2;
   logic [2:0] cnt5;
   logic [3:0] cnt10;
   logic [0:0] cnt2;
`ifdef DUTY40_TICK_EN
   logic       tick5, tick10, tick2;
`endif

   int checks   = 0;
   int failures = 0;

   // Model state: enabled edges since the last reset, and whether the last
   // edge started a new period.
   int  periods [3] = '{5, 10, 2};
   int  highs   [3] = '{2, 4, 1};
   int  k       [3];
   bit  tick_m  [3];

   always #5 clk = ~clk;

   duty_cycle_40 #(.PERIOD(5), .HIGH_CYCLES(2)) u_dut5 (
      .clk(clk), .rst(rst), .en(en), .clk_out(out5), .count(cnt5)
`ifdef DUTY40_TICK_EN
      , .period_tick(tick5)
`endif
   );

   duty_cycle_40 #(.PERIOD(10), .HIGH_CYCLES(4)) u_dut10 (
      .clk(clk), .rst(rst), .en(en), .clk_out(out10), .count(cnt10)
`ifdef DUTY40_TICK_EN
      , .period_tick(tick10)
`endif
   );

   duty_cycle_40 #(.PERIOD(2), .HIGH_CYCLES(1)) u_dut2 (
      .clk(clk), .rst(rst), .en(en), .clk_out(out2), .count(cnt2)
`ifdef DUTY40_TICK_EN
      , .period_tick(tick2)
`endif
   );

   task automatic check_val(input string tag, input int obs, input int exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
      end
   endtask

   function automatic int exp_count(input int i);
      return (k[i] == 0) ? periods[i] - 1 : (k[i] - 1) % periods[i];
   endfunction

   function automatic int exp_out(input int i);
      return (k[i] > 0 && ((k[i] - 1) % periods[i]) < highs[i]) ? 1 : 0;
   endfunction

   // Apply inputs, take one rising edge, advance the model, compare all instances.
   task automatic step(input bit r, input bit e);
      rst = r;
      en  = e;
      @(posedge clk);
      #1;
      for (int i = 0; i < 3; i++) begin
         if (r) begin
            k[i]      = 0;
            tick_m[i] = 1'b0;
         end else if (e) begin
            k[i]++;
            tick_m[i] = (((k[i] - 1) % periods[i]) == 0);
         end else begin
            tick_m[i] = 1'b0;
         end
      end
      check_val("p5_count",  int'(cnt5),  exp_count(0));
      check_val("p5_out",    int'(out5),  exp_out(0));
      check_val("p10_count", int'(cnt10), exp_count(1));
      check_val("p10_out",   int'(out10), exp_out(1));
      check_val("p2_count",  int'(cnt2),  exp_count(2));
      check_val("p2_out",    int'(out2),  exp_out(2));
`ifdef DUTY40_TICK_EN
      check_val("p5_tick",   int'(tick5),  int'(tick_m[0]));
      check_val("p10_tick",  int'(tick10), int'(tick_m[1]));
      check_val("p2_tick",   int'(tick2),  int'(tick_m[2]));
`endif
   endtask

   int high_cnt;

   initial begin
      for (int i = 0; i < 3; i++) begin
         k[i]      = 0;
         tick_m[i] = 1'b0;
      end

      // Reset for three edges.
      repeat (3) step(1'b1, 1'b1);
      check_val("rst_count", int'(cnt5), 4);
      check_val("rst_out",   int'(out5), 0);

      // Free run: 20 edges = 4 full periods, 8 high cycles.
      high_cnt = 0;
      for (int n = 0; n < 20; n++) begin
         step(1'b0, 1'b1);
         high_cnt += int'(out5);
         if (n == 0) check_val("first_edge_out", int'(out5), 1);
      end
      check_val("free_run_high", high_cnt, 8);

      // Move to phase 1, then hold en low for three edges.
      step(1'b0, 1'b1);
      step(1'b0, 1'b1);
      check_val("gap_entry_count", int'(cnt5), 1);
      repeat (3) step(1'b0, 1'b0);
      check_val("gap_hold_count", int'(cnt5), 1);
      check_val("gap_hold_out",   int'(out5), 1);
      repeat (4) step(1'b0, 1'b1);
      check_val("gap_resume_count", int'(cnt5), 0);
      check_val("gap_resume_out",   int'(out5), 1);

      // Mid-run reset at phase 3.
      repeat (3) step(1'b0, 1'b1);
      check_val("mid_entry_count", int'(cnt5), 3);
      step(1'b1, 1'b1);
      check_val("mid_rst_count", int'(cnt5), 4);
      check_val("mid_rst_out",   int'(out5), 0);
      step(1'b0, 1'b1);
      check_val("mid_release_count", int'(cnt5), 0);
      check_val("mid_release_out",   int'(out5), 1);

      // Randomized traffic: mostly enabled, occasional reset.
      for (int n = 0; n < 400; n++) begin
         step(($urandom_range(0, 39) == 0), ($urandom_range(0, 4) != 0));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
